// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Registered issue/retire stage around a combinational 32-bit ALU
// (r = op(a, b, f)). Requests are queued in a small command FIFO, presented
// to the ALU from a registered operand stage, and the ALU result is captured
// in a result register. Both sides use valid/ready handshakes. Results leave
// in acceptance order.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready request handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b        32-bit operands
//   cmd_f               3-bit ALU function code (7 is illegal)
//   cmd_tag             4-bit opaque tag returned with the result
//   alu_a, alu_b, alu_f registered operands driven into the ALU
//   alu_r               combinational ALU result
//   res_valid/res_ready result handshake
//   res_r, res_tag      result data and its tag
//   res_err             set when the function code was 7
//   retired             count of results handed off, wraps mod 2^CNTW
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_a,
    input  logic [31:0]     cmd_b,
    input  logic [2:0]      cmd_f,
    input  logic [3:0]      cmd_tag,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [2:0]      alu_f,
    input  logic [31:0]     alu_r,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_r,
    output logic [3:0]      res_tag,
    output logic            res_err,
    output logic [CNTW-1:0] retired
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + 32 + 3 + 4;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [2:0]    F_ILLEGAL = 3'd7;

    // ------------------------------------------------------------------
    // Command FIFO storage. Small enough for distributed RAM, so the head
    // entry is read combinationally; contents need no reset because the
    // occupancy count alone decides what is valid.
    // ------------------------------------------------------------------
    logic [EW-1:0] fifo_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          op_v_q,     op_v_d;
    logic [31:0]   alu_a_q,    alu_a_d;
    logic [31:0]   alu_b_q,    alu_b_d;
    logic [2:0]    alu_f_q,    alu_f_d;
    logic [3:0]    op_tag_q,   op_tag_d;

    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_r_q,     res_r_d;
    logic [3:0]    res_tag_q,   res_tag_d;
    logic          res_err_q,   res_err_d;
    logic [CNTW-1:0] retired_q, retired_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          res_free;
    logic          res_load;
    logic          op_take;
    logic          handoff;
    logic [EW-1:0] head;

    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        // cmd_ready depends only on the registered count, so a pop in the
        // same cycle never lets a push through a full FIFO.
        push     = cmd_valid && !full;
        res_free = !res_valid_q || res_ready;
        res_load = op_v_q && res_free;
        // Operand stage may take a new entry when empty or when its current
        // contents are moving into the result register this cycle.
        op_take  = !op_v_q || res_load;
        pop      = op_take && !empty;
        handoff  = res_valid_q && res_ready;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

        // Operand register: operands hold their last values when idle so the
        // ALU inputs do not toggle needlessly.
        op_v_d   = op_v_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_f_d  = alu_f_q;
        op_tag_d = op_tag_q;
        if (op_take) begin
            op_v_d = !empty;
            if (!empty) begin
                {alu_a_d, alu_b_d, alu_f_d, op_tag_d} = head;
            end
        end

        res_valid_d = res_valid_q;
        res_r_d     = res_r_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        if (res_load) begin
            res_valid_d = 1'b1;
            res_tag_d   = op_tag_q;
            if (alu_f_q == F_ILLEGAL) begin
                res_r_d   = '0;
                res_err_d = 1'b1;
            end else begin
                res_r_d   = alu_r;
                res_err_d = 1'b0;
            end
        end else if (handoff) begin
            res_valid_d = 1'b0;
        end

        retired_d = handoff ? retired_q + CNTW'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_a, cmd_b, cmd_f, cmd_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_v_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            op_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_r_q     <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_v_q      <= op_v_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            op_tag_q    <= op_tag_d;
            res_valid_q <= res_valid_d;
            res_r_q     <= res_r_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
            retired_q   <= retired_d;
        end
    end

    assign cmd_ready = !full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_f     = alu_f_q;
    assign res_valid = res_valid_q;
    assign res_r     = res_r_q;
    assign res_tag   = res_tag_q;
    assign res_err   = res_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//
// Directed testbench for alu_issue with a stub ALU (r = a + b + f).
// The DUT is built with DEPTH=4 and CNTW=4 so the retired counter wrap is
// reachable within a short run.
// ---------------------------------------------------------------------------
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_f;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_r;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_r;
    logic [3:0]  res_tag;
    logic        res_err;
    logic [3:0]  retired;

    int checks   = 0;
    int failures = 0;

    // Stream vectors: function code, tag, expected result, expected error.
    logic [2:0]  vf   [20];
    logic [3:0]  vtag [20];
    logic [31:0] vr   [20];
    logic        verr [20];

    alu_issue #(
        .DEPTH(4),
        .CNTW (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_f    (cmd_f),
        .cmd_tag  (cmd_tag),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_f    (alu_f),
        .alu_r    (alu_r),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_r    (res_r),
        .res_tag  (res_tag),
        .res_err  (res_err),
        .retired  (retired)
    );

    // Stub ALU
    assign alu_r = alu_a + alu_b + {29'd0, alu_f};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push n vectors (a=2, b=3) on consecutive cycles with res_ready high and
    // expect each result exactly two edges after its acceptance.
    task automatic stream(input int n, input string name);
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                cmd_valid = 1'b1;
                cmd_a     = 32'd2;
                cmd_b     = 32'd3;
                cmd_f     = vf[k];
                cmd_tag   = vtag[k];
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            if (k >= 2) begin
                check($sformatf("%s[%0d].valid", name, k - 2), 32'(res_valid), 32'd1);
                check($sformatf("%s[%0d].r", name, k - 2), res_r, vr[k - 2]);
                check($sformatf("%s[%0d].tag", name, k - 2), 32'(res_tag), 32'(vtag[k - 2]));
                check($sformatf("%s[%0d].err", name, k - 2), 32'(res_err), 32'(verr[k - 2]));
            end
        end
        step();
        check($sformatf("%s.drained", name), 32'(res_valid), 32'd0);
    endtask

    int accepts;
    logic acc_now;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_f     = '0;
        cmd_tag   = '0;
        res_ready = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst.res_valid", 32'(res_valid), 32'd0);
        check("rst.alu_a", alu_a, 32'd0);
        check("rst.res_r", res_r, 32'd0);
        check("rst.retired", 32'(retired), 32'd0);
        #5;
        rst_n = 1'b1;
        step();

        // ---------------- 1: single op ----------------
        cmd_valid = 1'b1;
        cmd_a     = 32'd2;
        cmd_b     = 32'd3;
        cmd_f     = 3'd0;
        cmd_tag   = 4'd1;
        step();                                   // E0: accepted
        cmd_valid = 1'b0;
        check("single.E0.res_valid", 32'(res_valid), 32'd0);
        step();                                   // E1: operand stage
        check("single.E1.res_valid", 32'(res_valid), 32'd0);
        check("single.E1.alu_a", alu_a, 32'd2);
        check("single.E1.alu_b", alu_b, 32'd3);
        check("single.E1.alu_f", 32'(alu_f), 32'd0);
        step();                                   // E2: result
        check("single.E2.res_valid", 32'(res_valid), 32'd1);
        check("single.E2.res_r", res_r, 32'd5);
        check("single.E2.res_tag", 32'(res_tag), 32'd1);
        check("single.E2.res_err", 32'(res_err), 32'd0);
        check("single.E2.retired", 32'(retired), 32'd0);
        res_ready = 1'b1;
        step();                                   // handoff
        check("single.handoff.res_valid", 32'(res_valid), 32'd0);
        check("single.handoff.retired", 32'(retired), 32'd1);

        // ---------------- 2: streaming f=0..6 ----------------
        for (int i = 0; i < 7; i++) begin
            vf[i]   = 3'(i);
            vtag[i] = 4'(i + 2);
            verr[i] = 1'b0;
        end
        vr[0] = 32'd5;  vr[1] = 32'd6;  vr[2] = 32'd7;  vr[3] = 32'd8;
        vr[4] = 32'd9;  vr[5] = 32'd10; vr[6] = 32'd11;
        stream(7, "stream");
        check("stream.retired", 32'(retired), 32'd8);

        // ---------------- 3: illegal op ----------------
        vf[0] = 3'd7; vtag[0] = 4'd9;  vr[0] = 32'd0; verr[0] = 1'b1;
        vf[1] = 3'd1; vtag[1] = 4'd10; vr[1] = 32'd6; verr[1] = 1'b0;
        stream(2, "illegal");
        check("illegal.retired", 32'(retired), 32'd10);

        // ---------------- 4: back-pressure ----------------
        res_ready = 1'b0;
        accepts   = 0;
        cmd_valid = 1'b1;
        cmd_a     = 32'd2;
        cmd_b     = 32'd3;
        cmd_f     = 3'd0;
        cmd_tag   = 4'd0;
        for (int c = 0; c < 10; c++) begin
            acc_now = cmd_ready;
            step();
            if (acc_now) begin
                accepts++;
                cmd_f   = 3'(accepts);
                cmd_tag = 4'(accepts);
            end
            if (res_valid) begin
                check($sformatf("bp.cyc%0d.res_r", c), res_r, 32'd5);
            end
        end
        cmd_valid = 1'b0;
        check("bp.accepts", 32'(accepts), 32'd6);
        check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp.res_tag", 32'(res_tag), 32'd0);
        check("bp.alu_f_held", 32'(alu_f), 32'd1);
        check("bp.retired_held", 32'(retired), 32'd10);
        res_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            check($sformatf("drain[%0d].valid", n), 32'(res_valid), 32'd1);
            check($sformatf("drain[%0d].r", n), res_r, 32'(5 + n));
            check($sformatf("drain[%0d].tag", n), 32'(res_tag), 32'(n));
            step();
            if (n == 0) begin
                check("drain.cmd_ready", 32'(cmd_ready), 32'd1);
            end
        end
        check("drain.done", 32'(res_valid), 32'd0);
        check("drain.retired_wrap", 32'(retired), 32'd0);

        // ---------------- 5: reset mid-operation ----------------
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = 32'd20;
        cmd_b     = 32'd30;
        for (int i = 0; i < 3; i++) begin
            cmd_f   = 3'(i + 1);
            cmd_tag = 4'(i + 5);
            step();
        end
        cmd_valid = 1'b0;
        check("pre_rst.res_valid", 32'(res_valid), 32'd1);
        check("pre_rst.res_r", res_r, 32'd51);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.res_valid", 32'(res_valid), 32'd0);
        check("arst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst.alu_a", alu_a, 32'd0);
        check("arst.alu_b", alu_b, 32'd0);
        check("arst.alu_f", 32'(alu_f), 32'd0);
        check("arst.res_r", res_r, 32'd0);
        check("arst.res_tag", 32'(res_tag), 32'd0);
        check("arst.retired", 32'(retired), 32'd0);
        #3;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst[%0d].res_valid", i), 32'(res_valid), 32'd0);
        end

        // ---------------- 6: counter wrap ----------------
        for (int i = 0; i < 17; i++) begin
            vf[i]   = 3'd0;
            vtag[i] = 4'(i);
            vr[i]   = 32'd5;
            verr[i] = 1'b0;
        end
        stream(17, "wrap");
        check("wrap.retired", 32'(retired), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
